// File: rtl/mem_access_sequencer_if.sv
// rtl/mem_access_sequencer_if.sv - request, response and memory bus bundle for mem_access_sequencer
//
// Purpose : groups the fetch port, the data (LDR/STR) port and the memory
//           array port of the sequencer into one bundle.
// Modports: slave  - the sequencer itself (takes requests, drives memory)
//           master - the surrounding core / memory model side
// Signals : fetch_req/fetch_addr/fetch_done/fetch_instr   fetch port
//           data_req/data_rw/data_addr/data_wdata/data_done/data_rdata  data port
//           mem_en/mem_rw/mem_addr/mem_wdata/mem_rdata      memory port
//           busy                                           ACCESS or DONE
//           fetch_stall_cnt                                only with MEM_SEQ_PERF_EN
// Macro   : MEM_SEQ_PERF_EN adds fetch_stall_cnt.

interface mem_access_sequencer_if #(
    parameter int PC_W   = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [PC_W-1:0]   fetch_addr;
    logic              fetch_done;
    logic [DATA_W-1:0] fetch_instr;
    logic              data_req;
    logic              data_rw;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_done;
    logic [DATA_W-1:0] data_rdata;
    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
`ifdef MEM_SEQ_PERF_EN
    logic [15:0]       fetch_stall_cnt;
`endif

    modport slave (
        input  fetch_req, fetch_addr, data_req, data_rw, data_addr, data_wdata, mem_rdata,
        output fetch_done, fetch_instr, data_done, data_rdata,
        output mem_en, mem_rw, mem_addr, mem_wdata, busy
`ifdef MEM_SEQ_PERF_EN
        , output fetch_stall_cnt
`endif
    );

    modport master (
        output fetch_req, fetch_addr, data_req, data_rw, data_addr, data_wdata, mem_rdata,
        input  fetch_done, fetch_instr, data_done, data_rdata,
        input  mem_en, mem_rw, mem_addr, mem_wdata, busy
`ifdef MEM_SEQ_PERF_EN
        , input fetch_stall_cnt
`endif
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - single-port memory sequencer arbitrating fetch and data accesses
//
// Purpose : shares one memory between instruction fetch and LDR/STR. Data
//           wins over fetch. The winner's address/rw/wdata are driven with
//           mem_en for MEM_LAT cycles, read data is captured on the last
//           access edge, and a one-cycle done pulse follows.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-low reset
//           bus   - mem_access_sequencer_if.slave (fetch, data and memory ports, busy)
// Macro   : MEM_SEQ_PERF_EN adds the saturating 16-bit fetch_stall_cnt output.

module mem_access_sequencer #(
    parameter int PC_W    = 8,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_access_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_data_q, owner_data_d;   // 1: data port owns the access
    logic              mem_en_q, mem_en_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              fetch_done_q, fetch_done_d;
    logic              data_done_q, data_done_d;
    logic [DATA_W-1:0] fetch_instr_q, fetch_instr_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              busy_q, busy_d;
`ifdef MEM_SEQ_PERF_EN
    logic [15:0]       stall_q, stall_d;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_data_d  = owner_data_q;
        mem_en_d      = mem_en_q;
        mem_rw_d      = mem_rw_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        fetch_done_d  = 1'b0;
        data_done_d   = 1'b0;
        fetch_instr_d = fetch_instr_q;
        data_rdata_d  = data_rdata_q;

        case (state_q)
            S_IDLE: begin
                mem_en_d    = 1'b0;
                mem_rw_d    = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                if (bus.data_req) begin
                    owner_data_d = 1'b1;
                    mem_en_d     = 1'b1;
                    mem_rw_d     = bus.data_rw;
                    mem_addr_d   = bus.data_addr;
                    mem_wdata_d  = bus.data_rw ? bus.data_wdata : '0;
                    cnt_d        = LAT_INIT;
                    state_d      = S_ACCESS;
                end else if (bus.fetch_req) begin
                    owner_data_d = 1'b0;
                    mem_en_d     = 1'b1;
                    mem_addr_d   = ADDR_W'(bus.fetch_addr);
                    cnt_d        = LAT_INIT;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // mem_rw_q still reflects the access in flight on this edge
                    if (!mem_rw_q) begin
                        if (owner_data_q) data_rdata_d  = bus.mem_rdata;
                        else              fetch_instr_d = bus.mem_rdata;
                    end
                    fetch_done_d = !owner_data_q;
                    data_done_d  = owner_data_q;
                    mem_en_d     = 1'b0;
                    mem_rw_d     = 1'b0;
                    mem_addr_d   = '0;
                    mem_wdata_d  = '0;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

`ifdef MEM_SEQ_PERF_EN
    // A fetch is stalled while data is being granted in IDLE or owns ACCESS/DONE.
    always_comb begin
        stall_d = stall_q;
        if (bus.fetch_req && (stall_q != 16'hFFFF) &&
            (((state_q == S_IDLE) && bus.data_req) ||
             ((state_q != S_IDLE) && owner_data_q)))
            stall_d = stall_q + 16'd1;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            owner_data_q  <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            fetch_done_q  <= 1'b0;
            data_done_q   <= 1'b0;
            fetch_instr_q <= '0;
            data_rdata_q  <= '0;
            busy_q        <= 1'b0;
`ifdef MEM_SEQ_PERF_EN
            stall_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_data_q  <= owner_data_d;
            mem_en_q      <= mem_en_d;
            mem_rw_q      <= mem_rw_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            fetch_done_q  <= fetch_done_d;
            data_done_q   <= data_done_d;
            fetch_instr_q <= fetch_instr_d;
            data_rdata_q  <= data_rdata_d;
            busy_q        <= busy_d;
`ifdef MEM_SEQ_PERF_EN
            stall_q       <= stall_d;
`endif
        end
    end

    assign bus.mem_en      = mem_en_q;
    assign bus.mem_rw      = mem_rw_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.fetch_done  = fetch_done_q;
    assign bus.data_done   = data_done_q;
    assign bus.fetch_instr = fetch_instr_q;
    assign bus.data_rdata  = data_rdata_q;
    assign bus.busy        = busy_q;
`ifdef MEM_SEQ_PERF_EN
    assign bus.fetch_stall_cnt = stall_q;
`endif
endmodule
